result_addr_gen: RTL and testbench

- Generates the memory address and write strobe for storing one captured-frame result record in the sniffer's result memory.
- Each `inc_addr` pulse from the match/capture logic advances the address by one fixed-size record slot (0x060E bytes) and asserts `write_enable` for one cycle.
- Sits between the capture controller and the result-memory write port.

---
 rtl/result_addr_pkg.sv | 14 +
 rtl/result_addr_gen_if.sv | 20 ++
 rtl/result_slot_counter.sv | 38 +++
 rtl/result_addr_gen.sv | 53 +++++
 tb/tb_result_addr_gen.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/result_addr_pkg.sv
// Shared types and constants for the sniffer result-memory address generator.
package result_addr_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      WRITE = 2'b01
   } state_t;

   // One captured-frame result record occupies 1550 bytes.
   localparam logic [31:0] RESULT_SLOT_BYTES = 32'h0000_060E;
   localparam logic [31:0] RESULT_BASE_ADDR  = 32'h0000_0000;
   localparam int          RESULT_NUM_SLOTS  = 16;

endpackage

// File: rtl/result_addr_gen_if.sv
// Capture-controller to result-memory address generator handshake.
interface result_addr_gen_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  inc_addr;
   logic [ADDR_WIDTH-1:0] addr_out;
   logic                  write_enable;

   modport master (
      output inc_addr,
      input  addr_out,
      input  write_enable
   );

   modport slave (
      input  inc_addr,
      output addr_out,
      output write_enable
   );
endinterface

// File: rtl/result_slot_counter.sv
// Registered result-slot address: adds one stride per enabled cycle and wraps
// back to the base address after the last slot.
module result_slot_counter
   import result_addr_pkg::*;
#(
   parameter int                    ADDR_WIDTH  = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(RESULT_BASE_ADDR),
   parameter logic [ADDR_WIDTH-1:0] ADDR_STRIDE = ADDR_WIDTH'(RESULT_SLOT_BYTES),
   parameter int                    NUM_SLOTS   = RESULT_NUM_SLOTS
) (
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic                  i_inc,
   output logic [ADDR_WIDTH-1:0] o_addr
);

   // Address of the final slot; computed modulo 2^ADDR_WIDTH like the datapath.
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR =
      BASE_ADDR + ADDR_WIDTH'(NUM_SLOTS - 1) * ADDR_STRIDE;

   logic [ADDR_WIDTH-1:0] r_addr;
   logic [ADDR_WIDTH-1:0] w_next_addr;
   logic                  w_last_slot;

   assign w_last_slot = (r_addr == LAST_ADDR);
   assign w_next_addr = w_last_slot ? BASE_ADDR : (r_addr + ADDR_STRIDE);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_addr <= BASE_ADDR;
      end else if (i_inc) begin
         r_addr <= w_next_addr;
      end
   end

   assign o_addr = r_addr;

endmodule

// File: rtl/result_addr_gen.sv
// Result-memory address generator: one write strobe per inc_addr cycle, with the
// slot address pre-incremented so the strobe and new address appear together.
module result_addr_gen
   import result_addr_pkg::*;
#(
   parameter int                    ADDR_WIDTH  = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(RESULT_BASE_ADDR),
   parameter logic [ADDR_WIDTH-1:0] ADDR_STRIDE = ADDR_WIDTH'(RESULT_SLOT_BYTES),
   parameter int                    NUM_SLOTS   = RESULT_NUM_SLOTS
) (
   input  logic              clk,
   input  logic              n_rst,
   result_addr_gen_if.slave  bus
);

   state_t                r_state;
   state_t                w_state_next;
   logic [ADDR_WIDTH-1:0] w_addr;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Every high inc_addr cycle produces exactly one WRITE cycle, back-to-back included.
   always_comb begin
      w_state_next = IDLE;
      case (r_state)
         IDLE:    if (bus.inc_addr) w_state_next = WRITE;
         WRITE:   if (bus.inc_addr) w_state_next = WRITE;
         default: w_state_next = IDLE;
      endcase
   end

   result_slot_counter #(
      .ADDR_WIDTH  (ADDR_WIDTH),
      .BASE_ADDR   (BASE_ADDR),
      .ADDR_STRIDE (ADDR_STRIDE),
      .NUM_SLOTS   (NUM_SLOTS)
   ) u_slot_counter (
      .clk    (clk),
      .n_rst  (n_rst),
      .i_inc  (bus.inc_addr),
      .o_addr (w_addr)
   );

   assign bus.addr_out     = w_addr;
   assign bus.write_enable = (r_state == WRITE);

endmodule

// File: tb/tb_result_addr_gen.sv
// Scoreboard bench for result_addr_gen: default instance plus a base/stride override instance.
module tb_result_addr_gen;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
   } exp_t;

   localparam logic [31:0] A_BASE   = 32'h0000_0000;
   localparam logic [31:0] A_STRIDE = 32'h0000_060E;
   localparam logic [31:0] B_BASE   = 32'h0000_1000;
   localparam logic [31:0] B_STRIDE = 32'h0000_0010;
   localparam int          SLOTS    = 16;

   logic clk;
   logic n_rst;

   result_addr_gen_if #(.ADDR_WIDTH(32)) bus_a ();
   result_addr_gen_if #(.ADDR_WIDTH(32)) bus_b ();

   result_addr_gen u_dut_a (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus_a)
   );

   result_addr_gen #(
      .ADDR_WIDTH  (32),
      .BASE_ADDR   (B_BASE),
      .ADDR_STRIDE (B_STRIDE),
      .NUM_SLOTS   (SLOTS)
   ) u_dut_b (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   exp_t        q_a[$];
   exp_t        q_b[$];
   logic [31:0] m_addr_a;
   logic [31:0] m_addr_b;
   int          n_checks = 0;
   int          n_fail   = 0;

   function automatic logic [31:0] model_next(input logic [31:0] cur,
                                              input logic [31:0] base,
                                              input logic [31:0] stride);
      logic [31:0] last;
      last = base + 32'(SLOTS - 1) * stride;
      return (cur == last) ? base : cur + stride;
   endfunction

   // Drive one cycle of inc_addr on both instances and queue what should appear after the edge.
   task automatic drive_cycle(input bit inc_a, input bit inc_b);
      exp_t e;
      bus_a.inc_addr = inc_a;
      bus_b.inc_addr = inc_b;
      if (inc_a) m_addr_a = model_next(m_addr_a, A_BASE, A_STRIDE);
      if (inc_b) m_addr_b = model_next(m_addr_b, B_BASE, B_STRIDE);
      e.we = inc_a; e.addr = m_addr_a; q_a.push_back(e);
      e.we = inc_b; e.addr = m_addr_b; q_b.push_back(e);
      @(posedge clk);
      #1;
      bus_a.inc_addr = 1'b0;
      bus_b.inc_addr = 1'b0;
   endtask

   task automatic apply_reset();
      n_rst = 1'b0;
      bus_a.inc_addr = 1'b0;
      bus_b.inc_addr = 1'b0;
      q_a.delete();
      q_b.delete();
      m_addr_a = A_BASE;
      m_addr_b = B_BASE;
      repeat (2) @(posedge clk);
      #1;
      n_rst = 1'b1;
   endtask

   task automatic test_reset();
      exp_t e;
      n_rst = 1'b0;
      bus_a.inc_addr = 1'b0;
      bus_b.inc_addr = 1'b0;
      m_addr_a = A_BASE;
      m_addr_b = B_BASE;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (bus_a.write_enable !== 1'b0 || bus_a.addr_out !== 32'h0000_0000) begin
         n_fail++;
         $display("FAIL reset_a: got we=%b addr=%h, expected we=0 addr=00000000",
                  bus_a.write_enable, bus_a.addr_out);
      end
      n_checks++;
      if (bus_b.write_enable !== 1'b0 || bus_b.addr_out !== 32'h0000_1000) begin
         n_fail++;
         $display("FAIL reset_b: got we=%b addr=%h, expected we=0 addr=00001000",
                  bus_b.write_enable, bus_b.addr_out);
      end
      n_rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive_cycle(1'b0, 1'b0);
         e = q_a.pop_front();
         void'(q_b.pop_front());
         n_checks++;
         if (bus_a.write_enable !== e.we || bus_a.addr_out !== e.addr) begin
            n_fail++;
            $display("FAIL reset_idle[%0d]: got we=%b addr=%h, expected we=%b addr=%h",
                     i, bus_a.write_enable, bus_a.addr_out, e.we, e.addr);
         end
      end
   endtask

   task automatic test_single_pulses();
      exp_t        e;
      logic [31:0] tbl [4];
      tbl[0] = 32'h0000_060E; tbl[1] = 32'h0000_0C1C;
      tbl[2] = 32'h0000_122A; tbl[3] = 32'h0000_1838;
      apply_reset();
      for (int p = 0; p < 4; p++) begin
         for (int c = 0; c < 4; c++) begin
            drive_cycle(c == 0, 1'b0);
            e = q_a.pop_front();
            void'(q_b.pop_front());
            n_checks++;
            if (bus_a.write_enable !== e.we || bus_a.addr_out !== e.addr) begin
               n_fail++;
               $display("FAIL single[%0d.%0d]: got we=%b addr=%h, expected we=%b addr=%h",
                        p, c, bus_a.write_enable, bus_a.addr_out, e.we, e.addr);
            end
         end
         n_checks++;
         if (bus_a.addr_out !== tbl[p]) begin
            n_fail++;
            $display("FAIL single_addr[%0d]: got addr=%h, expected addr=%h",
                     p, bus_a.addr_out, tbl[p]);
         end
      end
   endtask

   task automatic test_back_to_back();
      exp_t        e;
      logic [31:0] tbl [3];
      tbl[0] = 32'h0000_060E; tbl[1] = 32'h0000_0C1C; tbl[2] = 32'h0000_122A;
      apply_reset();
      for (int c = 0; c < 4; c++) begin
         drive_cycle(c < 3, 1'b0);
         e = q_a.pop_front();
         void'(q_b.pop_front());
         n_checks++;
         if (bus_a.write_enable !== (c < 3) || bus_a.addr_out !== tbl[(c < 3) ? c : 2]
             || bus_a.addr_out !== e.addr) begin
            n_fail++;
            $display("FAIL b2b[%0d]: got we=%b addr=%h, expected we=%b addr=%h",
                     c, bus_a.write_enable, bus_a.addr_out, e.we, e.addr);
         end
      end
   endtask

   task automatic test_wrap();
      exp_t e;
      apply_reset();
      for (int i = 1; i <= 17; i++) begin
         drive_cycle(1'b1, 1'b0);
         e = q_a.pop_front();
         void'(q_b.pop_front());
         n_checks++;
         if (bus_a.write_enable !== e.we || bus_a.addr_out !== e.addr) begin
            n_fail++;
            $display("FAIL wrap_seq[%0d]: got we=%b addr=%h, expected we=%b addr=%h",
                     i, bus_a.write_enable, bus_a.addr_out, e.we, e.addr);
         end
         if (i == 15) begin
            n_checks++;
            if (bus_a.addr_out !== 32'h0000_5AD2) begin
               n_fail++;
               $display("FAIL wrap_last: got addr=%h, expected addr=00005ad2", bus_a.addr_out);
            end
         end else if (i == 16) begin
            n_checks++;
            if (bus_a.addr_out !== 32'h0000_0000 || bus_a.write_enable !== 1'b1) begin
               n_fail++;
               $display("FAIL wrap_base: got we=%b addr=%h, expected we=1 addr=00000000",
                        bus_a.write_enable, bus_a.addr_out);
            end
         end else if (i == 17) begin
            n_checks++;
            if (bus_a.addr_out !== 32'h0000_060E) begin
               n_fail++;
               $display("FAIL wrap_next: got addr=%h, expected addr=0000060e", bus_a.addr_out);
            end
         end
      end
      drive_cycle(1'b0, 1'b0);
      void'(q_a.pop_front());
      void'(q_b.pop_front());
   endtask

   task automatic test_async_reset();
      exp_t e;
      apply_reset();
      drive_cycle(1'b1, 1'b1);
      e = q_a.pop_front();
      void'(q_b.pop_front());
      n_checks++;
      if (bus_a.write_enable !== 1'b1 || bus_a.addr_out !== e.addr) begin
         n_fail++;
         $display("FAIL async_pre: got we=%b addr=%h, expected we=1 addr=%h",
                  bus_a.write_enable, bus_a.addr_out, e.addr);
      end
      #2;
      n_rst = 1'b0;
      m_addr_a = A_BASE;
      m_addr_b = B_BASE;
      #1;
      n_checks++;
      if (bus_a.write_enable !== 1'b0 || bus_a.addr_out !== 32'h0000_0000) begin
         n_fail++;
         $display("FAIL async_a: got we=%b addr=%h, expected we=0 addr=00000000",
                  bus_a.write_enable, bus_a.addr_out);
      end
      n_checks++;
      if (bus_b.write_enable !== 1'b0 || bus_b.addr_out !== 32'h0000_1000) begin
         n_fail++;
         $display("FAIL async_b: got we=%b addr=%h, expected we=0 addr=00001000",
                  bus_b.write_enable, bus_b.addr_out);
      end
      @(posedge clk);
      #1;
      n_rst = 1'b1;
   endtask

   task automatic test_param_override();
      exp_t        e;
      logic [31:0] tbl [3];
      tbl[0] = 32'h0000_1010; tbl[1] = 32'h0000_1020; tbl[2] = 32'h0000_1020;
      apply_reset();
      for (int c = 0; c < 3; c++) begin
         drive_cycle(1'b0, c < 2);
         void'(q_a.pop_front());
         e = q_b.pop_front();
         n_checks++;
         if (bus_b.write_enable !== e.we || bus_b.addr_out !== e.addr
             || bus_b.addr_out !== tbl[c]) begin
            n_fail++;
            $display("FAIL param[%0d]: got we=%b addr=%h, expected we=%b addr=%h",
                     c, bus_b.write_enable, bus_b.addr_out, e.we, tbl[c]);
         end
      end
   endtask

   initial begin
      n_rst = 1'b0;
      bus_a.inc_addr = 1'b0;
      bus_b.inc_addr = 1'b0;
      test_reset();
      test_single_pulses();
      test_back_to_back();
      test_wrap();
      test_async_reset();
      test_param_override();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
